// File: rtl/spi_cmd_pkg.sv
// Sprite-engine command definitions shared by the host-side SPI sender and the
// receiver-side command parser: opcode values and payload length per opcode.
// Pure constants/functions; no logic, no latency, no flow control.
package spi_cmd_pkg;

  localparam logic [7:0] CMD_SEND_SPRITE = 8'h00;
  localparam logic [7:0] CMD_DRAW_SPRITE = 8'h01;

  // Sprite id byte plus 512 pixel bytes.
  localparam logic [15:0] SEND_SPRITE_LEN = 16'd513;
  localparam logic [15:0] DRAW_SPRITE_LEN = 16'd2;

  // Number of payload bytes that follow the opcode byte; unknown opcodes are
  // sent as a bare opcode byte.
  function automatic logic [15:0] cmd_payload_len(input logic [7:0] opcode);
    case (opcode)
      CMD_SEND_SPRITE: cmd_payload_len = SEND_SPRITE_LEN;
      CMD_DRAW_SPRITE: cmd_payload_len = DRAW_SPRITE_LEN;
      default:         cmd_payload_len = 16'd0;
    endcase
  endfunction

endpackage

// File: rtl/spi_sck_divider.sv
// SPI half-period timer: reloads to CLK_DIV-1 on load, counts down, holds at 0.
// Latency: tick is high while the count is 0, i.e. CLK_DIV cycles after a load.
// Backpressure: none; the owning FSM decides when a phase starts via load.
//
// Ports: clk, rst_n (async active-low), load (start a new half-period),
//        tick (current cycle is the last one of the half-period).
module spi_sck_divider #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic tick
);

  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 8'd0;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign tick = (cnt == 8'd0);

endmodule

// File: rtl/spi_command_sender.sv
// SPI mode-0 master that sends an opcode byte followed by its payload bytes.
// Latency: cs_n falls the cycle after acceptance; unstalled frame holds cs_n low (16*N+1)*CLK_DIV cycles.
// Backpressure: cmd_ready only in IDLE; a missing payload byte parks the link with sck low until it arrives.
//
// Ports: clk, rst_n (async active-low); cmd_valid/cmd_ready/cmd_opcode command
//        handshake; payload_valid/payload_ready/payload_data byte handshake;
//        busy; SPI link cs_n, sck, mosi.
// Build option: define SPI_SENDER_ABORT_EN to add the abort input, which ends
//        the current frame early through HOLD and GAP.
module spi_command_sender
  import spi_cmd_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef SPI_SENDER_ABORT_EN
  input  logic       abort,
`endif
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_opcode,
  input  logic       payload_valid,
  output logic       payload_ready,
  input  logic [7:0] payload_data,
  output logic       busy,
  output logic       cs_n,
  output logic       sck,
  output logic       mosi
);

  typedef enum logic [2:0] {IDLE, SETUP, SCK_HIGH, SCK_LOW, FETCH, HOLD, GAP} state_t;

  state_t      state, state_d;
  logic [6:0]  shift_q;     // bits of the current byte still to be sent after mosi
  logic [2:0]  bit_cnt;     // index of the bit currently on mosi, 0 = MSB
  logic [15:0] remaining;   // payload bytes not yet fetched
  logic        cs_n_q, sck_q, mosi_q;

  logic        div_load, tick;
  logic        accept, take, shift_en;
  logic        abort_req;

`ifdef SPI_SENDER_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  spi_sck_divider #(.CLK_DIV(CLK_DIV)) u_div (
    .clk  (clk),
    .rst_n(rst_n),
    .load (div_load),
    .tick (tick)
  );

  always_comb begin
    state_d  = state;
    div_load = 1'b0;
    accept   = 1'b0;
    take     = 1'b0;
    shift_en = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept   = 1'b1;
          state_d  = SETUP;
          div_load = 1'b1;
        end
      end
      SETUP, SCK_LOW: begin
        if (tick) begin
          state_d  = SCK_HIGH;
          div_load = 1'b1;
        end
      end
      SCK_HIGH: begin
        if (tick) begin
          div_load = 1'b1;
          if (bit_cnt != 3'd7) begin
            shift_en = 1'b1;
            state_d  = SCK_LOW;
          end else if (remaining != 16'd0) begin
            state_d = FETCH;
          end else begin
            state_d = HOLD;
          end
        end
      end
      FETCH: begin
        // The cycle a byte is taken is the first cycle of its low phase: its
        // MSB reaches mosi through the bypass below in that same cycle, so the
        // phase still lasts CLK_DIV cycles but an unstalled fetch costs nothing
        // extra. The counter keeps running into SCK_LOW rather than reloading.
        if (payload_valid) begin
          take = 1'b1;
          if (tick) begin
            state_d  = SCK_HIGH;
            div_load = 1'b1;
          end else begin
            state_d = SCK_LOW;
          end
        end else begin
          div_load = 1'b1;  // park with a full low phase ready to start
        end
      end
      HOLD: begin
        if (tick) begin
          state_d  = GAP;
          div_load = 1'b1;
        end
      end
      GAP: begin
        if (tick) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // HOLD and GAP are already closing the frame; restarting HOLD from GAP
    // would drop cs_n again, so abort only acts while bytes are in flight.
    if (abort_req && (state == SETUP || state == SCK_HIGH ||
                      state == SCK_LOW || state == FETCH)) begin
      state_d  = HOLD;
      div_load = 1'b1;
      take     = 1'b0;
      shift_en = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_q   <= 7'd0;
      bit_cnt   <= 3'd0;
      remaining <= 16'd0;
      cs_n_q    <= 1'b1;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
    end else begin
      state  <= state_d;
      // Link outputs are registered from the next state so they never glitch.
      cs_n_q <= (state_d == IDLE) || (state_d == GAP);
      sck_q  <= (state_d == SCK_HIGH);
      if (accept) begin
        shift_q   <= cmd_opcode[6:0];
        mosi_q    <= cmd_opcode[7];
        bit_cnt   <= 3'd0;
        remaining <= cmd_payload_len(cmd_opcode);
      end else if (take) begin
        shift_q   <= payload_data[6:0];
        mosi_q    <= payload_data[7];
        bit_cnt   <= 3'd0;
        remaining <= remaining - 16'd1;
      end else if (shift_en) begin
        shift_q <= {shift_q[5:0], 1'b0};
        mosi_q  <= shift_q[6];
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  assign cmd_ready     = (state == IDLE);
  assign busy          = (state != IDLE);
  assign payload_ready = take;
  assign cs_n          = cs_n_q;
  assign sck           = sck_q;
  assign mosi          = take ? payload_data[7] : mosi_q;

endmodule
